// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer with run/step/halt control,
// saturating retire/jump counters and auto-halt of runaway jump loops.
module cpu_sequencer #(
    parameter int COUNT_W    = 16,
    parameter int JUMP_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic               clear,
    input  logic [1:0]         opcode,
    output logic               ir_load,
    output logic               alu_en,
    output logic               rf_we,
    output logic               pc_inc,
    output logic               pc_clr,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] jump_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] LIMIT   = COUNT_W'(JUMP_LIMIT);

    logic               single_step;
    logic               single_step_next;
    logic               halt_pending;
    logic [2:0]         state_next;
    logic               jump_taken;
    logic               retire;
    logic               auto_halt;
    logic               stop_now;
    logic [2:0]         boundary_next;
    logic [COUNT_W-1:0] instr_inc;
    logic [COUNT_W-1:0] jump_inc;

    always_comb begin
        jump_taken = (state == EXEC) && (opcode == 2'b11);
        retire     = (state == WB) || jump_taken;
        instr_inc  = (instr_count == CNT_MAX) ? instr_count : instr_count + COUNT_W'(1);
        jump_inc   = (jump_count == CNT_MAX) ? jump_count : jump_count + COUNT_W'(1);
        // Auto-halt compares against the count this jump produces, saturated.
        auto_halt  = (JUMP_LIMIT != 0) && jump_taken && (jump_inc == LIMIT);
        stop_now   = (!clear && (halt_pending || halt_req)) || auto_halt;

        if (stop_now) begin
            boundary_next = HALT;
        end else if (single_step || !run) begin
            boundary_next = IDLE;
        end else begin
            boundary_next = FETCH;
        end

        state_next       = state;
        single_step_next = single_step;
        case (state)
            IDLE: begin
                if (step) begin
                    state_next       = FETCH;
                    single_step_next = 1'b1;
                end else if (run) begin
                    state_next       = FETCH;
                    single_step_next = 1'b0;
                end
            end
            FETCH:   state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = jump_taken ? boundary_next : WB;
            WB:      state_next = boundary_next;
            HALT:    state_next = clear ? IDLE : HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            single_step  <= 1'b0;
            halt_pending <= 1'b0;
            instr_count  <= '0;
            jump_count   <= '0;
        end else begin
            state       <= state_next;
            single_step <= single_step_next;
            // Clear beats any same-cycle increment or halt request.
            if (clear) begin
                halt_pending <= 1'b0;
                instr_count  <= '0;
                jump_count   <= '0;
            end else begin
                if (halt_req && (state != HALT)) begin
                    halt_pending <= 1'b1;
                end
                if (retire) begin
                    instr_count <= instr_inc;
                end
                if (jump_taken) begin
                    jump_count <= jump_inc;
                end
            end
        end
    end

    assign ir_load = (state == FETCH);
    assign alu_en  = (state == EXEC);
    assign rf_we   = (state == WB);
    assign pc_inc  = (state == WB);
    assign pc_clr  = jump_taken;
    assign busy    = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected per-cycle states are queued as
// stimulus is driven and compared with the DUT outputs one cycle at a time.
module tb_cpu_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic        clk = 1'b0;
    logic        rst, run, step, halt_req, clear;
    logic [1:0]  opcode;

    logic        ir_load_a, alu_en_a, rf_we_a, pc_inc_a, pc_clr_a, busy_a, halted_a;
    logic [2:0]  state_a;
    logic [15:0] instr_count_a, jump_count_a;

    logic        ir_load_b, alu_en_b, rf_we_b, pc_inc_b, pc_clr_b, busy_b, halted_b;
    logic [2:0]  state_b;
    logic [3:0]  instr_count_b, jump_count_b;

    int compared   = 0;
    int mismatched = 0;

    logic [2:0] exp_q[$];

    cpu_sequencer #(.COUNT_W(16), .JUMP_LIMIT(8)) dut_a (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
        .clear(clear), .opcode(opcode), .ir_load(ir_load_a), .alu_en(alu_en_a),
        .rf_we(rf_we_a), .pc_inc(pc_inc_a), .pc_clr(pc_clr_a), .state(state_a),
        .busy(busy_a), .halted(halted_a), .instr_count(instr_count_a),
        .jump_count(jump_count_a)
    );

    cpu_sequencer #(.COUNT_W(4), .JUMP_LIMIT(8)) dut_b (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
        .clear(clear), .opcode(opcode), .ir_load(ir_load_b), .alu_en(alu_en_b),
        .rf_we(rf_we_b), .pc_inc(pc_inc_b), .pc_clr(pc_clr_b), .state(state_b),
        .busy(busy_b), .halted(halted_b), .instr_count(instr_count_b),
        .jump_count(jump_count_b)
    );

    always #5 clk = ~clk;

    // Expected output vector {state, busy, halted, ir_load, alu_en, rf_we, pc_inc, pc_clr}
    function automatic logic [9:0] expect_vec(input logic [2:0] st, input logic [1:0] op);
        logic b;
        b = (st >= S_FETCH) && (st <= S_WB);
        return {st, b, st == S_HALT, st == S_FETCH, st == S_EXEC, st == S_WB, st == S_WB,
                (st == S_EXEC) && (op == 2'b11)};
    endfunction

    function automatic logic [9:0] observe_a();
        return {state_a, busy_a, halted_a, ir_load_a, alu_en_a, rf_we_a, pc_inc_a, pc_clr_a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; clear = 1'b0; opcode = 2'b00;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            run      = 1'($urandom_range(0, 1));
            step     = 1'($urandom_range(0, 1));
            halt_req = ($urandom_range(0, 7) == 0);
            opcode   = 2'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        got = observe_a();
        compared++;
        if (got !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", got, 10'd0);
        end
        compared++;
        if (instr_count_a !== 16'd0 || jump_count_a !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", instr_count_a, jump_count_a);
        end
        compared++;
        if (state_b !== S_IDLE || instr_count_b !== 4'd0 || jump_count_b !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_dut_b: got state %0d counts %0d/%0d expected 0 0/0",
                     state_b, instr_count_b, jump_count_b);
        end
        rst = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; opcode = 2'b00;
        tick();
    endtask

    task automatic test_step();
        logic [2:0] e;
        logic [9:0] got;
        opcode = 2'b00;
        step   = 1'b1;
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_EXEC);
        exp_q.push_back(S_WB);
        exp_q.push_back(S_IDLE);
        exp_q.push_back(S_IDLE);
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            step = 1'b0;
            e    = exp_q.pop_front();
            got  = observe_a();
            compared++;
            if (got !== expect_vec(e, opcode)) begin
                mismatched++;
                $display("[TB] FAIL step_seq cycle %0d: got %b expected %b", c, got, expect_vec(e, opcode));
            end
        end
        compared++;
        if (instr_count_a !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL step_instr_count: got %0d expected 1", instr_count_a);
        end
    endtask

    task automatic test_jump_loop();
        logic [2:0] e;
        logic [9:0] got;
        int clr_pulses = 0;
        int we_pulses  = 0;
        opcode = 2'b11;
        run    = 1'b1;
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back(S_FETCH);
            exp_q.push_back(S_DECODE);
            exp_q.push_back(S_EXEC);
        end
        exp_q.push_back(S_HALT);
        exp_q.push_back(S_HALT);
        exp_q.push_back(S_HALT);
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            if (pc_clr_a) clr_pulses++;
            if (rf_we_a) we_pulses++;
            e   = exp_q.pop_front();
            got = observe_a();
            compared++;
            if (got !== expect_vec(e, opcode)) begin
                mismatched++;
                $display("[TB] FAIL jump_seq cycle %0d: got %b expected %b", c, got, expect_vec(e, opcode));
            end
        end
        compared++;
        if (clr_pulses != 8 || we_pulses != 0) begin
            mismatched++;
            $display("[TB] FAIL jump_pulses: got pc_clr %0d rf_we %0d expected 8 0", clr_pulses, we_pulses);
        end
        compared++;
        if (jump_count_a !== 16'd8 || instr_count_a !== 16'd9 || jump_count_b !== 4'd8) begin
            mismatched++;
            $display("[TB] FAIL jump_counts: got jump %0d instr %0d jump_b %0d expected 8 9 8",
                     jump_count_a, instr_count_a, jump_count_b);
        end
        run   = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        compared++;
        if (state_a !== S_IDLE || instr_count_a !== 16'd0 || jump_count_a !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL jump_clear: got state %0d counts %0d/%0d expected 0 0/0",
                     state_a, instr_count_a, jump_count_a);
        end
    endtask

    task automatic test_halt_req();
        logic [2:0] e;
        logic [9:0] got;
        opcode = 2'b01;
        run    = 1'b1;
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_EXEC);
        exp_q.push_back(S_WB);
        for (int k = 0; k < 4; k++) exp_q.push_back(S_HALT);
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            e   = exp_q.pop_front();
            got = observe_a();
            compared++;
            if (got !== expect_vec(e, opcode)) begin
                mismatched++;
                $display("[TB] FAIL halt_seq cycle %0d: got %b expected %b", c, got, expect_vec(e, opcode));
            end
            halt_req = (c == 1);
        end
        compared++;
        if (instr_count_a !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL halt_instr_count: got %0d expected 1", instr_count_a);
        end
        run   = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        compared++;
        if (state_a !== S_IDLE || instr_count_a !== 16'd0 || jump_count_a !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL halt_clear: got state %0d counts %0d/%0d expected 0 0/0",
                     state_a, instr_count_a, jump_count_a);
        end
        tick();
        compared++;
        if (state_a !== S_IDLE) begin
            mismatched++;
            $display("[TB] FAIL halt_pending_cleared: got state %0d expected 0", state_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        logic [9:0] got;
        opcode = 2'b10;
        step   = 1'b1;
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_EXEC);
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            step = 1'b0;
            e    = exp_q.pop_front();
            got  = observe_a();
            compared++;
            if (got !== expect_vec(e, opcode)) begin
                mismatched++;
                $display("[TB] FAIL rstmid_seq cycle %0d: got %b expected %b", c, got, expect_vec(e, opcode));
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = observe_a();
        compared++;
        if (got !== 10'd0 || instr_count_a !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_abort: got %b count %0d expected %b count 0", got, instr_count_a, 10'd0);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] e;
        logic [9:0] got;
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        opcode = 2'b00;
        run    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(S_FETCH);
            exp_q.push_back(S_DECODE);
            exp_q.push_back(S_EXEC);
            exp_q.push_back(S_WB);
        end
        exp_q.push_back(S_IDLE);
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            e   = exp_q.pop_front();
            got = observe_a();
            compared++;
            if (got !== expect_vec(e, opcode)) begin
                mismatched++;
                $display("[TB] FAIL sat_seq cycle %0d: got %b expected %b", c, got, expect_vec(e, opcode));
            end
            if (c == 79) run = 1'b0;
        end
        compared++;
        if (instr_count_a !== 16'd20) begin
            mismatched++;
            $display("[TB] FAIL sat_count_wide: got %0d expected 20", instr_count_a);
        end
        compared++;
        if (instr_count_b !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL sat_count_narrow: got %0d expected 15", instr_count_b);
        end
    endtask

    task automatic test_run_step_both();
        logic [2:0] e;
        logic [9:0] got;
        opcode = 2'b00;
        run    = 1'b1;
        step   = 1'b1;
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_EXEC);
        exp_q.push_back(S_WB);
        exp_q.push_back(S_IDLE);
        exp_q.push_back(S_IDLE);
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            step = 1'b0;
            if (c == 4) run = 1'b0;
            e   = exp_q.pop_front();
            got = observe_a();
            compared++;
            if (got !== expect_vec(e, opcode)) begin
                mismatched++;
                $display("[TB] FAIL both_seq cycle %0d: got %b expected %b", c, got, expect_vec(e, opcode));
            end
        end
        compared++;
        if (instr_count_a !== 16'd21 || instr_count_b !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL both_count: got %0d/%0d expected 21/15", instr_count_a, instr_count_b);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_jump_loop();
        test_halt_req();
        test_reset_mid();
        test_saturate();
        test_run_step_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
